vdp_port_ctrl: RTL and testbench
================================

VDP_PORT_CTRL -- requirements
Module: vdp_port_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of data-port write FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ctrl_wr, input, 1 bit: one-cycle strobe for a control-port write (CPU address 0xC00004).
REQ-005 SHALL have port ctrl_in, input, 16 bits: control-port write word.
REQ-006 SHALL have port data_wr, input, 1 bit: one-cycle strobe for a data-port write (CPU address 0xC00000).
REQ-007 SHALL have port data_in, input, 16 bits: data-port write word.
REQ-008 SHALL have port reg_sel, input, 5 bits: register read-back index.
REQ-009 SHALL have port reg_val, output, 8 bits: contents of register reg_sel (combinational).
REQ-010 SHALL have port mem_req, output, 1 bit: memory write request.
REQ-011 SHALL have port mem_ack, input, 1 bit: memory write accept.
REQ-012 SHALL have port mem_tgt, output, 2 bits: write target; 0 = VRAM, 1 = CRAM, 2 = VSRAM.
REQ-013 SHALL have port mem_addr, output, 16 bits: memory write address.
REQ-014 SHALL have port mem_data, output, 16 bits: memory write data.
REQ-015 SHALL have port fifo_empty, output, 1 bit: FIFO holds no entries.
REQ-016 SHALL have port fifo_full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, set when a data write is dropped.
REQ-018 SHALL have port cmd_pending, output, 1 bit: first command word latched, second word awaited.

Function
REQ-019 SHALL hold 24 registers, 8 bits each (indices 0-23); reg_val SHALL read 0x00 for reg_sel >= 24.
REQ-020 SHALL treat a control write with cmd_pending=0 and ctrl_in[15:14]=2'b10 as a register write: reg[ctrl_in[12:8]] <= ctrl_in[7:0] on the next edge; indices >= 24 are ignored; the code and address registers are unchanged.
REQ-021 SHALL treat any other control write with cmd_pending=0 as command word 1: code[1:0] <= ctrl_in[15:14]; addr[13:0] <= ctrl_in[13:0]; cmd_pending <= 1.
REQ-022 SHALL treat a control write with cmd_pending=1 as command word 2: code[5:2] <= ctrl_in[7:4]; addr[15:14] <= ctrl_in[1:0]; cmd_pending <= 0.
REQ-023 SHALL, on any data_wr, clear cmd_pending. Code and address keep their current partial values.
REQ-024 SHALL decode code[3:0]: 4'b0001 is VRAM, 4'b0011 is CRAM, 4'b0101 is VSRAM. All other codes are non-writing.
REQ-025 SHALL, on data_wr with a writing code and the FIFO not full, push {tgt, addr, data_in} into the FIFO.
REQ-026 SHALL, on every data_wr (writing code or not, dropped or not), advance addr <= addr + reg[15], modulo 2^16.
REQ-027 SHALL, on data_wr with a writing code while the FIFO is full and no pop occurs in the same cycle, drop the write and set overflow; overflow SHALL clear only on rst.
REQ-028 SHALL ignore ctrl_wr when it is asserted in the same cycle as data_wr; the data write is processed normally.
REQ-029 SHALL run a two-state drain FSM. IDLE: mem_req=0; go to REQ when the FIFO is non-empty. REQ: mem_req=1 with mem_tgt/mem_addr/mem_data taken from the FIFO head and held stable; on mem_ack, pop the head, then stay in REQ if entries remain, else go to IDLE.
REQ-030 SHALL give a latency of exactly one cycle from a push edge to mem_req=1 when the FIFO was empty.
REQ-031 SHALL accept a push and a pop in the same cycle, including when the FIFO is full; the occupancy is then unchanged.
REQ-032 SHALL ignore mem_ack while in IDLE.
REQ-033 SHALL keep entries in strict FIFO order; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, apply the following regardless of any operation in flight. Registers 0-23: 0x00. code: 0. addr: 0. cmd_pending: 0. FIFO emptied. FSM: IDLE. mem_req: 0. mem_tgt, mem_addr, mem_data: 0. fifo_empty: 1. fifo_full: 0. overflow: 0.
REQ-035 SHALL ignore ctrl_wr, data_wr and mem_ack in any cycle in which rst=1.

Verification
REQ-036 Register write: ctrl 0x8F02 -> reg[15]=0x02 and cmd_pending=0. Then ctrl 0x9F55 (index 31) -> no register changes.
REQ-037 VRAM write: reg15=2; ctrl 0x4000 then 0x0000; data 0x1234, 0x5678 -> two requests (VRAM, 0x0000, 0x1234) and (VRAM, 0x0002, 0x5678); mem_req rises one cycle after the first push.
REQ-038 CRAM write with wrap: reg15=2; ctrl 0xFFFE then 0x0003 (code 0x03, addr 0xFFFE); two data writes -> requests to CRAM at addresses 0xFFFE then 0x0000.
REQ-039 Overflow: hold mem_ack=0; five data writes with FIFO_DEPTH=4 -> fifo_full=1, the fifth write dropped, overflow=1, address still advanced five times. Then release mem_ack -> exactly four requests, in order.
REQ-040 Pending and collision cases: ctrl 0x4000 then data_wr -> cmd_pending=0 and the write goes to VRAM at 0x0000. ctrl_wr and data_wr in the same cycle -> the ctrl word has no effect.
REQ-041 Reset mid-operation: rst asserted while mem_req=1 with 3 entries queued -> next cycle mem_req=0, fifo_empty=1, all registers 0x00, overflow=0.

Source files
------------

// File: rtl/vdp_port_ctrl.sv
// VDP control/data port front end: register file, two-word command latch, write FIFO, memory drain FSM.
// mem_req rises one cycle after a push into an empty FIFO; data writes arriving while full (no pop) are dropped.
module vdp_port_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr,
    input  logic [15:0] ctrl_in,
    input  logic        data_wr,
    input  logic [15:0] data_in,
    input  logic [4:0]  reg_sel,
    output logic [7:0]  reg_val,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [1:0]  mem_tgt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow,
    output logic        cmd_pending
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0]  tgt;
        logic [15:0] addr;
        logic [15:0] dat;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    logic [7:0]    regs [0:23];
    logic [5:0]    code;
    logic [15:0]   addr;
    logic          pend;
    logic          ovf;
    entry_t        fifo_mem [0:FIFO_DEPTH-1];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_nxt;
    logic          writing;
    logic [1:0]    wr_tgt;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    always_comb begin
        writing = 1'b1;
        wr_tgt  = 2'd0;
        case (code[3:0])
            4'b0001: wr_tgt = 2'd0;
            4'b0011: wr_tgt = 2'd1;
            4'b0101: wr_tgt = 2'd2;
            default: writing = 1'b0;
        endcase
    end

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (state == REQ) && mem_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = data_wr && writing && (!full || pop);
    assign drop = data_wr && writing && full && !pop;
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = REQ;
            REQ:  if (pop && !push && count == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) fifo_mem[wr_ptr] <= '{tgt: wr_tgt, addr: addr, dat: data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 24; i++) regs[i] <= 8'h00;
            code   <= '0;
            addr   <= '0;
            pend   <= 1'b0;
            ovf    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (data_wr) begin
                pend <= 1'b0;
                addr <= addr + {8'h00, regs[15]};
            end else if (ctrl_wr) begin
                if (!pend && ctrl_in[15:14] == 2'b10) begin
                    if (ctrl_in[12:8] < 5'd24) regs[ctrl_in[12:8]] <= ctrl_in[7:0];
                end else if (!pend) begin
                    code[1:0]  <= ctrl_in[15:14];
                    addr[13:0] <= ctrl_in[13:0];
                    pend       <= 1'b1;
                end else begin
                    code[5:2]   <= ctrl_in[7:4];
                    addr[15:14] <= ctrl_in[1:0];
                    pend        <= 1'b0;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    assign reg_val     = (reg_sel < 5'd24) ? regs[reg_sel] : 8'h00;
    assign mem_req     = (state == REQ);
    assign mem_tgt     = mem_req ? head.tgt  : 2'd0;
    assign mem_addr    = mem_req ? head.addr : 16'h0000;
    assign mem_data    = mem_req ? head.dat  : 16'h0000;
    assign fifo_empty  = (count == '0);
    assign fifo_full   = full;
    assign overflow    = ovf;
    assign cmd_pending = pend;
endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: vector table, directed corner sequences, and randomized traffic vs a queue-based model.
module tb_vdp_port_ctrl;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst, ctrl_wr, data_wr, mem_ack;
    logic [15:0] ctrl_in, data_in;
    logic [4:0]  reg_sel;
    logic [7:0]  reg_val;
    logic        mem_req, fifo_empty, fifo_full, overflow, cmd_pending;
    logic [1:0]  mem_tgt;
    logic [15:0] mem_addr, mem_data;

    always #5 clk = ~clk;

    vdp_port_ctrl #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ctrl_wr(ctrl_wr), .ctrl_in(ctrl_in),
        .data_wr(data_wr), .data_in(data_in), .reg_sel(reg_sel), .reg_val(reg_val),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_tgt(mem_tgt), .mem_addr(mem_addr),
        .mem_data(mem_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .overflow(overflow), .cmd_pending(cmd_pending)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: what the port has been told, plus the ordered list of writes still owed to memory.
    logic [7:0]  m_regs [0:23];
    logic [5:0]  m_code;
    logic [15:0] m_addr;
    logic        m_pend, m_req, m_ovf;
    logic [33:0] m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Returns {writes, target} for a code.
    function automatic logic [2:0] decode(input logic [3:0] c);
        if (c == 4'd1) return 3'b100;
        if (c == 4'd3) return 3'b101;
        if (c == 4'd5) return 3'b110;
        return 3'b000;
    endfunction

    task automatic model_update();
        logic [2:0]  dec;
        logic        popped, had;
        logic [7:0]  inc;
        if (rst) begin
            for (int i = 0; i < 24; i++) m_regs[i] = 8'h00;
            m_code = 0; m_addr = 0; m_pend = 0; m_req = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        popped = m_req && mem_ack;
        had    = (m_q.size() != 0);
        if (popped) void'(m_q.pop_front());
        if (data_wr) begin
            dec = decode(m_code[3:0]);
            if (dec[2]) begin
                if (m_q.size() < D) m_q.push_back({dec[1:0], m_addr, data_in});
                else m_ovf = 1;
            end
            m_pend = 0;
            inc = m_regs[15];
            m_addr = m_addr + {8'h00, inc};
        end else if (ctrl_wr) begin
            if (!m_pend && ctrl_in[15:14] == 2'b10) begin
                if (ctrl_in[12:8] < 24) m_regs[ctrl_in[12:8]] = ctrl_in[7:0];
            end else if (!m_pend) begin
                m_code[1:0] = ctrl_in[15:14]; m_addr[13:0] = ctrl_in[13:0]; m_pend = 1;
            end else begin
                m_code[5:2] = ctrl_in[7:4]; m_addr[15:14] = ctrl_in[1:0]; m_pend = 0;
            end
        end
        // Requesting continues while work remains; from idle it starts one cycle after work appears.
        m_req = m_req ? (m_q.size() != 0) : had;
    endtask

    task automatic compare();
        logic [7:0] er;
        er = (reg_sel < 24) ? m_regs[reg_sel] : 8'h00;
        chk("m_req", mem_req, m_req);
        if (m_req && m_q.size() != 0) begin
            chk("m_tgt",  mem_tgt,  m_q[0][33:32]);
            chk("m_addr", mem_addr, m_q[0][31:16]);
            chk("m_data", mem_data, m_q[0][15:0]);
        end
        chk("m_empty", fifo_empty, m_q.size() == 0);
        chk("m_full",  fifo_full,  m_q.size() == D);
        chk("m_ovf",   overflow,   m_ovf);
        chk("m_pend",  cmd_pending, m_pend);
        chk("m_reg",   reg_val, er);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic cyc(input logic cw, input logic [15:0] cv, input logic dw, input logic [15:0] dv);
        ctrl_wr = cw; ctrl_in = cv; data_wr = dw; data_in = dv;
        step();
        ctrl_wr = 0; data_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    typedef struct {
        logic        cw;
        logic [15:0] cv;
        logic        dw;
        logic [15:0] dv;
        logic [4:0]  sel;
        logic [7:0]  exp_reg;
        logic        exp_pend;
    } vec_t;

    vec_t tv[9];
    logic [15:0] got_addr[$];
    logic [15:0] got_data[$];

    initial begin
        rst = 1; ctrl_wr = 0; data_wr = 0; mem_ack = 0; ctrl_in = 0; data_in = 0; reg_sel = 0;
        for (int i = 0; i < 24; i++) m_regs[i] = 8'hxx;
        step();
        rst = 0;
        chk("rst_req", mem_req, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_pend", cmd_pending, 0);

        tv[0] = '{1, 16'h8F02, 0, 16'h0, 5'd15, 8'h02, 0};
        tv[1] = '{1, 16'h9F55, 0, 16'h0, 5'd31, 8'h00, 0};
        tv[2] = '{0, 16'h0,    0, 16'h0, 5'd15, 8'h02, 0};
        tv[3] = '{1, 16'h9755, 0, 16'h0, 5'd23, 8'h55, 0};
        tv[4] = '{1, 16'h9866, 0, 16'h0, 5'd24, 8'h00, 0};
        tv[5] = '{1, 16'h4000, 0, 16'h0, 5'd15, 8'h02, 1};
        tv[6] = '{1, 16'h8F09, 0, 16'h0, 5'd15, 8'h02, 0};
        tv[7] = '{1, 16'h4000, 0, 16'h0, 5'd23, 8'h55, 1};
        tv[8] = '{0, 16'h0,    1, 16'h1111, 5'd15, 8'h02, 0};
        for (int i = 0; i < 9; i++) begin
            reg_sel = tv[i].sel;
            cyc(tv[i].cw, tv[i].cv, tv[i].dw, tv[i].dv);
            chk($sformatf("vec%0d_reg", i), reg_val, tv[i].exp_reg);
            chk($sformatf("vec%0d_pend", i), cmd_pending, tv[i].exp_pend);
        end

        // VRAM burst, first-request latency, in-order drain
        do_reset(); reg_sel = 15;
        cyc(1, 16'h8F02, 0, 0); cyc(1, 16'h4000, 0, 0); cyc(1, 16'h0000, 0, 0);
        cyc(0, 0, 1, 16'h1234);
        chk("vram_lat0", mem_req, 0);
        cyc(0, 0, 1, 16'h5678);
        chk("vram_req1", mem_req, 1);
        chk("vram_a1", mem_addr, 16'h0000); chk("vram_d1", mem_data, 16'h1234); chk("vram_t1", mem_tgt, 0);
        mem_ack = 1; step();
        chk("vram_a2", mem_addr, 16'h0002); chk("vram_d2", mem_data, 16'h5678);
        step(); mem_ack = 0;
        chk("vram_done", mem_req, 0);

        // CRAM with address wrap, ack held high while idle
        do_reset(); mem_ack = 1;
        cyc(1, 16'h8F02, 0, 0); cyc(1, 16'hFFFE, 0, 0); cyc(1, 16'h0003, 0, 0);
        cyc(0, 0, 1, 16'h0EEE); cyc(0, 0, 1, 16'h0AAA);
        chk("cram_t1", mem_tgt, 1); chk("cram_a1", mem_addr, 16'hFFFE);
        step();
        chk("cram_t2", mem_tgt, 1); chk("cram_a2", mem_addr, 16'h0000);
        step(); mem_ack = 0;

        // Overflow then drain
        do_reset();
        cyc(1, 16'h8F02, 0, 0); cyc(1, 16'h4000, 0, 0); cyc(1, 16'h0000, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'hA000 + 16'(i));
        chk("ovf_full", fifo_full, 1); chk("ovf_flag", overflow, 1);
        mem_ack = 1;
        for (int i = 0; i < 12; i++) begin
            if (mem_req) begin got_addr.push_back(mem_addr); got_data.push_back(mem_data); end
            step();
        end
        mem_ack = 0;
        chk("ovf_nreq", got_addr.size(), 4);
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            chk($sformatf("ovf_a%0d", i), got_addr[i], 16'(2 * i));
            chk($sformatf("ovf_d%0d", i), got_data[i], 16'hA000 + 16'(i));
        end
        cyc(0, 0, 1, 16'hBEEF); step();
        chk("ovf_next_addr", mem_addr, 16'h000A);
        chk("ovf_sticky", overflow, 1);

        // Pending cleared by data write; ctrl/data collision
        do_reset(); reg_sel = 15;
        cyc(1, 16'h4000, 0, 0);
        cyc(0, 0, 1, 16'hAAAA);
        chk("pend_clr", cmd_pending, 0);
        step();
        chk("pend_t", mem_tgt, 0); chk("pend_a", mem_addr, 0); chk("pend_d", mem_data, 16'hAAAA);
        cyc(1, 16'h8F07, 1, 16'h5555);
        chk("coll_reg15", reg_val, 8'h00); chk("coll_pend", cmd_pending, 0);

        // Reset with traffic in flight
        do_reset();
        cyc(1, 16'h8F02, 0, 0); cyc(1, 16'h8355, 0, 0); cyc(1, 16'h4000, 0, 0); cyc(1, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'hC000 + 16'(i));
        chk("mid_req", mem_req, 1);
        rst = 1; mem_ack = 1; cyc(1, 16'h8F09, 1, 16'h7777); rst = 0; mem_ack = 0;
        chk("mid_req0", mem_req, 0); chk("mid_empty", fifo_empty, 1); chk("mid_ovf", overflow, 0);
        reg_sel = 3;  #1 chk("mid_reg3", reg_val, 0);
        reg_sel = 15; #1 chk("mid_reg15", reg_val, 0);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            int r;
            rst     = ($urandom_range(0, 299) == 0);
            mem_ack = ((n / 64) % 3 == 0) ? ($urandom_range(0, 9) == 0) : $urandom_range(0, 1);
            data_wr = ($urandom_range(0, 99) < 35);
            ctrl_wr = ($urandom_range(0, 99) < 25);
            data_in = 16'($urandom);
            reg_sel = 5'($urandom);
            r = $urandom_range(0, 3);
            ctrl_in = 16'($urandom);
            case (r)
                0: begin ctrl_in[15:13] = 3'b100;
                         if ($urandom_range(0, 1) == 1) begin ctrl_in[12:8] = 5'd15; ctrl_in[7:3] = 0; end end
                1: ctrl_in[15:14] = $urandom_range(0, 1) ? 2'b01 : 2'b11;
                2: ctrl_in[5] = 1'b0;
                default: ;
            endcase
            step();
        end
        rst = 0; ctrl_wr = 0; data_wr = 0; mem_ack = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
